// File: rtl/ex_pkg.sv
// Shared encodings for the MIPS execute stage: ALU operation classes,
// R-type function codes, branch kinds and operand forward selects.
package ex_pkg;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_RTYPE = 4'b0010;
  localparam logic [3:0] ALU_AND   = 4'b0011;
  localparam logic [3:0] ALU_OR    = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_LUI   = 4'b0110;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_BEQ  = 2'b01;
  localparam logic [1:0] BR_BNE  = 2'b10;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/ex_alu.sv
// Combinational ALU for the execute stage. Shifts operate on operand B by
// shamt; unknown operation or function codes produce zero.
module ex_alu
  import ex_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        aluOp,
  input  logic [5:0]        func,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] opA,
  input  logic [DATA_W-1:0] opB,
  output logic [DATA_W-1:0] result,
  output logic              zero
);

  // Operation select; all arithmetic wraps modulo 2^DATA_W
  always_comb begin
    result = '0;
    case (aluOp)
      ALU_ADD: result = opA + opB;
      ALU_SUB: result = opA - opB;
      ALU_AND: result = opA & opB;
      ALU_OR:  result = opA | opB;
      ALU_SLT: result[0] = $signed(opA) < $signed(opB);
      ALU_LUI: result = opB << 16;
      ALU_RTYPE: begin
        case (func)
          FN_ADD, FN_ADDU: result = opA + opB;
          FN_SUB, FN_SUBU: result = opA - opB;
          FN_AND:  result = opA & opB;
          FN_OR:   result = opA | opB;
          FN_XOR:  result = opA ^ opB;
          FN_NOR:  result = ~(opA | opB);
          FN_SLT:  result[0] = $signed(opA) < $signed(opB);
          FN_SLTU: result[0] = opA < opB;
          FN_SLL:  result = opB << shamt;
          FN_SRL:  result = opB >> shamt;
          FN_SRA:  result = $signed(opB) >>> shamt;
          default: result = '0;
        endcase
      end
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// MIPS pipeline execute stage: operand forwarding, ALU, branch resolution
// and the EX/MEM pipeline register. Define EX_FORWARDING_EN to forward
// from the MEM and WB stages; without it operands come straight from the
// register file and software must insert NOPs.
module execute_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] pc4,
  input  logic              mem_to_reg_in,
  input  logic              reg_write_in,
  input  logic              mem_write_in,
  input  logic              mem_read_in,
  input  logic [3:0]        alu_op,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic [1:0]        branch,
  input  logic [DATA_W-1:0] imm_ext,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [5:0]        func,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_reg_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              branch_taken,
  output logic [DATA_W-1:0] pc_branch,
  output logic              alu_zero,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              mem_to_reg,
  output logic              reg_write,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [REG_AW-1:0] mem_dest
);
  import ex_pkg::*;

  fwd_sel_e          fwdASel;
  fwd_sel_e          fwdBSel;
  logic [DATA_W-1:0] fwdRs;
  logic [DATA_W-1:0] fwdRt;
  logic [DATA_W-1:0] opB;
  logic [DATA_W-1:0] aluOut;

`ifdef EX_FORWARDING_EN
  // Forward selects: MEM result beats WB, and register 0 is never forwarded
  always_comb begin
    fwdASel = FWD_REG;
    fwdBSel = FWD_REG;
    if (reg_write && (mem_dest != '0) && (mem_dest == rs_addr))
      fwdASel = FWD_MEM;
    else if (wb_reg_write && (wb_reg_addr != '0) && (wb_reg_addr == rs_addr))
      fwdASel = FWD_WB;
    if (reg_write && (mem_dest != '0) && (mem_dest == rt_addr))
      fwdBSel = FWD_MEM;
    else if (wb_reg_write && (wb_reg_addr != '0) && (wb_reg_addr == rt_addr))
      fwdBSel = FWD_WB;
  end
`else
  assign fwdASel = FWD_REG;
  assign fwdBSel = FWD_REG;

  logic unusedFwdInputs;
  assign unusedFwdInputs = ^{rs_addr, rt_addr, wb_reg_write, wb_reg_addr, wb_data};
`endif

  assign fwd_a_sel = fwdASel;
  assign fwd_b_sel = fwdBSel;

  // Operand sources; the MEM source is the EX/MEM register itself
  always_comb begin
    fwdRs = rs_data;
    fwdRt = rt_data;
    case (fwdASel)
      FWD_WB:  fwdRs = wb_data;
      FWD_MEM: fwdRs = alu_result;
      default: fwdRs = rs_data;
    endcase
    case (fwdBSel)
      FWD_WB:  fwdRt = wb_data;
      FWD_MEM: fwdRt = alu_result;
      default: fwdRt = rt_data;
    endcase
  end

  assign opB = alu_src ? imm_ext : fwdRt;

  ex_alu #(.DATA_W(DATA_W)) uAlu (
    .aluOp  (alu_op),
    .func   (func),
    .shamt  (imm_ext[10:6]),
    .opA    (fwdRs),
    .opB    (opB),
    .result (aluOut),
    .zero   (alu_zero)
  );

  assign ex_dest      = reg_dst ? rd_addr : rt_addr;
  assign pc_branch    = pc4 + (imm_ext << 2);
  assign branch_taken = ((branch == BR_BEQ) && alu_zero) ||
                        ((branch == BR_BNE) && !alu_zero);

  // EX/MEM pipeline register; reset wins over capture
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_to_reg     <= 1'b0;
      reg_write      <= 1'b0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      alu_result     <= '0;
      mem_write_data <= '0;
      mem_dest       <= '0;
    end else begin
      mem_to_reg     <= mem_to_reg_in;
      reg_write      <= reg_write_in;
      mem_write      <= mem_write_in;
      mem_read       <= mem_read_in;
      alu_result     <= aluOut;
      mem_write_data <= fwdRt;
      mem_dest       <= ex_dest;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage. Each directed vector pushes its
// hand-computed expectation; the monitor checks the combinational outputs
// in the same cycle and the EX/MEM outputs one cycle later.
module tb_execute_stage;

`ifdef EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] pc4;
  logic        mem_to_reg_in, reg_write_in, mem_write_in, mem_read_in;
  logic [3:0]  alu_op;
  logic        alu_src, reg_dst;
  logic [1:0]  branch;
  logic [31:0] imm_ext;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic [31:0] rs_data, rt_data;
  logic [5:0]  func;
  logic        wb_reg_write;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_data;
  logic [4:0]  ex_dest;
  logic        branch_taken;
  logic [31:0] pc_branch;
  logic        alu_zero;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        mem_to_reg, reg_write, mem_write, mem_read;
  logic [31:0] alu_result, mem_write_data;
  logic [4:0]  mem_dest;

  execute_stage dut (
    .clk(clk), .reset(reset), .pc4(pc4),
    .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
    .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
    .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst), .branch(branch),
    .imm_ext(imm_ext), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .func(func),
    .wb_reg_write(wb_reg_write), .wb_reg_addr(wb_reg_addr), .wb_data(wb_data),
    .ex_dest(ex_dest), .branch_taken(branch_taken), .pc_branch(pc_branch),
    .alu_zero(alu_zero), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .mem_write(mem_write),
    .mem_read(mem_read), .alu_result(alu_result),
    .mem_write_data(mem_write_data), .mem_dest(mem_dest)
  );

  typedef struct {
    string       name;
    bit          chkComb;
    bit          chkReg;
    logic [4:0]  exDest;
    logic [1:0]  fa, fb;
    logic        zero, taken;
    logic [31:0] pcBr;
    logic        m2r, rw, mw, mr;
    logic [31:0] res, wdata;
    logic [4:0]  dest;
  } exp_t;

  exp_t expQ[$];
  exp_t prevExp, curExp;
  bit   havePrev;
  int   checks;
  int   errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic clearIn();
    pc4 = '0; mem_to_reg_in = 0; reg_write_in = 0; mem_write_in = 0; mem_read_in = 0;
    alu_op = '0; alu_src = 0; reg_dst = 0; branch = '0; imm_ext = '0;
    rs_addr = '0; rt_addr = '0; rd_addr = '0; rs_data = '0; rt_data = '0; func = '0;
    wb_reg_write = 0; wb_reg_addr = '0; wb_data = '0;
  endtask

  task automatic pushExp(input string nm, input bit cc, input bit cr,
                         input logic [4:0] exDest, input logic [1:0] fa, input logic [1:0] fb,
                         input logic zero, input logic taken, input logic [31:0] pcBr,
                         input logic m2r, input logic rw, input logic mw, input logic mr,
                         input logic [31:0] res, input logic [31:0] wdata, input logic [4:0] dest);
    exp_t e;
    e.name = nm; e.chkComb = cc; e.chkReg = cr;
    e.exDest = exDest; e.fa = fa; e.fb = fb; e.zero = zero; e.taken = taken; e.pcBr = pcBr;
    e.m2r = m2r; e.rw = rw; e.mw = mw; e.mr = mr; e.res = res; e.wdata = wdata; e.dest = dest;
    expQ.push_back(e);
  endtask

  task automatic nextVec();
    @(posedge clk);
    #1;
    clearIn();
  endtask

  // Monitor: combinational outputs belong to the vector now applied,
  // EX/MEM outputs to the vector captured at the last rising edge
  initial begin
    havePrev = 1'b0;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        curExp = expQ.pop_front();
        if (havePrev && prevExp.chkReg) begin
          check({prevExp.name, ".mem_to_reg"},     32'(mem_to_reg),     32'(prevExp.m2r));
          check({prevExp.name, ".reg_write"},      32'(reg_write),      32'(prevExp.rw));
          check({prevExp.name, ".mem_write"},      32'(mem_write),      32'(prevExp.mw));
          check({prevExp.name, ".mem_read"},       32'(mem_read),       32'(prevExp.mr));
          check({prevExp.name, ".alu_result"},     alu_result,          prevExp.res);
          check({prevExp.name, ".mem_write_data"}, mem_write_data,      prevExp.wdata);
          check({prevExp.name, ".mem_dest"},       32'(mem_dest),       32'(prevExp.dest));
        end
        if (curExp.chkComb) begin
          check({curExp.name, ".ex_dest"},      32'(ex_dest),      32'(curExp.exDest));
          check({curExp.name, ".fwd_a_sel"},    32'(fwd_a_sel),    32'(curExp.fa));
          check({curExp.name, ".fwd_b_sel"},    32'(fwd_b_sel),    32'(curExp.fb));
          check({curExp.name, ".alu_zero"},     32'(alu_zero),     32'(curExp.zero));
          check({curExp.name, ".branch_taken"}, 32'(branch_taken), 32'(curExp.taken));
          check({curExp.name, ".pc_branch"},    pc_branch,         curExp.pcBr);
        end
        prevExp  = curExp;
        havePrev = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clearIn();

    // Two reset edges with busy inputs: EX/MEM must stay zero
    nextVec();
    reset = 1; pc4 = 32'h40; mem_to_reg_in = 1; reg_write_in = 1; mem_write_in = 1; mem_read_in = 1;
    rs_data = 5; rt_data = 7; reg_dst = 1; rd_addr = 9;
    pushExp("rst0", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextVec();
    reset = 1; pc4 = 32'h40; mem_to_reg_in = 1; reg_write_in = 1; mem_write_in = 1; mem_read_in = 1;
    rs_data = 5; rt_data = 7; reg_dst = 1; rd_addr = 9;
    pushExp("rst1", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // R-type add 5+7 -> r3
    nextVec();
    reset = 0;
    rs_addr = 1; rs_data = 5; rt_addr = 2; rt_data = 7; alu_op = 4'b0010; func = 6'b100000;
    reg_dst = 1; rd_addr = 3; reg_write_in = 1;
    pushExp("add", 1, 1, 3, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'd12, 32'd7, 3);

    // sub using r3 forwarded from EX/MEM (12-2)
    nextVec();
    rs_addr = 3; rs_data = 0; rt_addr = 5; rt_data = 2; alu_op = 4'b0001; reg_write_in = 1;
    pushExp("memfwd", 1, 1, 5, FWD ? 2'b10 : 2'b00, 0, 0, 0, 0, 0, 1, 0, 0,
            FWD ? 32'd10 : 32'hFFFF_FFFE, 32'd2, 5);

    // addi 9 -> r4 to set up the priority case
    nextVec();
    alu_op = 4'b0000; alu_src = 1; imm_ext = 9; rt_addr = 4; reg_write_in = 1;
    pushExp("setup9", 1, 1, 4, 0, 0, 0, 0, 32'h24, 0, 1, 0, 0, 32'd9, 32'd0, 4);

    // MEM (9) and WB (1) both target r4: MEM wins
    nextVec();
    rs_addr = 4; rs_data = 32'h77; alu_src = 1; reg_write_in = 1;
    wb_reg_write = 1; wb_reg_addr = 4; wb_data = 1;
    pushExp("prio", 1, 1, 0, FWD ? 2'b10 : 2'b00, 0, 0, 0, 0, 0, 1, 0, 0,
            FWD ? 32'd9 : 32'h77, 32'd0, 0);

    // MEM and WB both target r0: never forwarded
    nextVec();
    rs_addr = 0; rs_data = 32'h33; rt_addr = 0; alu_src = 1;
    wb_reg_write = 1; wb_reg_addr = 0; wb_data = 1;
    pushExp("dest0", 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h33, 32'd0, 0);

    // WB-only forward into OR immediate
    nextVec();
    rs_addr = 6; rs_data = 5; alu_op = 4'b0100; alu_src = 1; imm_ext = 32'hF;
    reg_dst = 1; rd_addr = 7; wb_reg_write = 1; wb_reg_addr = 6; wb_data = 32'h1000;
    pushExp("wbfwd", 1, 1, 7, FWD ? 2'b01 : 2'b00, 0, 0, 0, 32'h3C, 0, 0, 0, 0,
            FWD ? 32'h100F : 32'hF, 32'd0, 7);

    // beq 6==6 taken, target 0x100 + (-2<<2)
    nextVec();
    pc4 = 32'h100; imm_ext = 32'hFFFF_FFFE; rs_addr = 8; rs_data = 6; rt_addr = 9; rt_data = 6;
    alu_op = 4'b0001; branch = 2'b01;
    pushExp("beq", 1, 1, 9, 0, 0, 1, 1, 32'hF8, 0, 0, 0, 0, 32'd0, 32'd6, 9);

    // bne with equal operands: not taken
    nextVec();
    pc4 = 32'h100; imm_ext = 32'hFFFF_FFFE; rs_addr = 8; rs_data = 6; rt_addr = 9; rt_data = 6;
    alu_op = 4'b0001; branch = 2'b10;
    pushExp("bne_eq", 1, 1, 9, 0, 0, 1, 0, 32'hF8, 0, 0, 0, 0, 32'd0, 32'd6, 9);

    // reserved branch code with zero result: never taken
    nextVec();
    pc4 = 32'h100; imm_ext = 32'hFFFF_FFFE; rs_addr = 8; rs_data = 6; rt_addr = 9; rt_data = 6;
    alu_op = 4'b0001; branch = 2'b11;
    pushExp("br_rsvd", 1, 1, 9, 0, 0, 1, 0, 32'hF8, 0, 0, 0, 0, 32'd0, 32'd6, 9);

    // bne with unequal operands: taken
    nextVec();
    pc4 = 32'h100; imm_ext = 32'hFFFF_FFFE; rs_addr = 8; rs_data = 6; rt_addr = 9; rt_data = 5;
    alu_op = 4'b0001; branch = 2'b10;
    pushExp("bne_ne", 1, 1, 9, 0, 0, 0, 1, 32'hF8, 0, 0, 0, 0, 32'd1, 32'd5, 9);

    // sw: address 0x20+8, store data forwarded from WB
    nextVec();
    pc4 = 32'h200; imm_ext = 8; alu_src = 1; rs_addr = 10; rs_data = 32'h20;
    rt_addr = 11; rt_data = 32'h55; mem_write_in = 1;
    wb_reg_write = 1; wb_reg_addr = 11; wb_data = 32'hAB;
    pushExp("sw", 1, 1, 11, 0, FWD ? 2'b01 : 2'b00, 0, 0, 32'h220, 0, 0, 1, 0,
            32'h28, FWD ? 32'hAB : 32'h55, 11);

    // sra by 4 of 0x80000000, with load-style control bits
    nextVec();
    alu_op = 4'b0010; func = 6'b000011; rt_addr = 12; rt_data = 32'h8000_0000; imm_ext = 32'h100;
    reg_dst = 1; rd_addr = 13; mem_read_in = 1; mem_to_reg_in = 1;
    pushExp("sra", 1, 1, 13, 0, 0, 0, 0, 32'h400, 1, 0, 0, 1, 32'hF800_0000, 32'h8000_0000, 13);

    // signed slt: -1 < 1
    nextVec();
    alu_op = 4'b0101; rs_addr = 1; rs_data = 32'hFFFF_FFFF; rt_addr = 2; rt_data = 1;
    reg_dst = 1; rd_addr = 3;
    pushExp("slt", 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'd1, 32'd1, 3);

    // unsigned sltu: 0xFFFFFFFF < 1 is false
    nextVec();
    alu_op = 4'b0010; func = 6'b101011; rs_addr = 1; rs_data = 32'hFFFF_FFFF; rt_addr = 2; rt_data = 1;
    reg_dst = 1; rd_addr = 3;
    pushExp("sltu", 1, 1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'd0, 32'd1, 3);

    // lui 0x1234
    nextVec();
    alu_op = 4'b0110; alu_src = 1; imm_ext = 32'h1234; rt_addr = 4;
    pushExp("lui", 1, 1, 4, 0, 0, 0, 0, 32'h48D0, 0, 0, 0, 0, 32'h1234_0000, 32'd0, 4);

    // nor
    nextVec();
    alu_op = 4'b0010; func = 6'b100111; rs_addr = 1; rs_data = 32'hF0F0_F0F0;
    rt_addr = 2; rt_data = 32'h0F0F_0000; reg_dst = 1; rd_addr = 5;
    pushExp("nor", 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0F0F, 32'h0F0F_0000, 5);

    // undefined alu_op gives zero
    nextVec();
    alu_op = 4'b0111; rs_addr = 1; rs_data = 3; rt_addr = 6; rt_data = 4;
    pushExp("badop", 1, 1, 6, 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'd0, 32'd4, 6);

    // idle slot lets the last vector's EX/MEM values be checked
    nextVec();
    pushExp("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
